// File: rtl/i2c_target_rx_if.sv
// I2C target receive bus bundle.
// Pad-side SCL/SDA plus the decoded register-write strobe.
interface i2c_target_rx_if;
  logic       scl_in;
  logic       sda_in;
  logic       sda_oe;
  logic       wr_valid;
  logic [7:0] wr_reg;
  logic [7:0] wr_data;
  logic       busy;

  modport master (
    output scl_in,
    output sda_in,
    input  sda_oe,
    input  wr_valid,
    input  wr_reg,
    input  wr_data,
    input  busy
  );

  modport slave (
    input  scl_in,
    input  sda_in,
    output sda_oe,
    output wr_valid,
    output wr_reg,
    output wr_data,
    output busy
  );
endinterface

// File: rtl/i2c_target_rx.sv
// I2C/SCCB write-only target: oversampled SCL/SDA,
// address match + ACK, register-write strobes.
module i2c_target_rx #(
  parameter logic [6:0] DEV_ADDR    = 7'h21,
  parameter int         SYNC_STAGES = 2
) (
  input  logic          ref_clk,
  input  logic          rst,
  i2c_target_rx_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE, ADDR, ACK_A, REG,
    ACK_R, DATA, ACK_D, IGNORE
  } state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_p_q;
  logic                   sda_p_q;
  logic [7:0]             shift_q;
  logic [3:0]             cnt_q;
  logic [7:0]             ptr_q;
  logic                   sda_oe_q;
  logic                   wr_valid_q;
  logic [7:0]             wr_reg_q;
  logic [7:0]             wr_data_q;
  logic                   busy_q;

  logic       scl_s;
  logic       sda_s;
  logic       scl_rise;
  logic       scl_fall;
  logic       start;
  logic       stop;
  logic [7:0] byte_d;
  logic       addr_hit;

  assign scl_s    = scl_sync_q[SYNC_STAGES-1];
  assign sda_s    = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_p_q;
  assign scl_fall = ~scl_s & scl_p_q;
  assign start    = scl_s & scl_p_q & sda_p_q & ~sda_s;
  assign stop     = scl_s & scl_p_q & ~sda_p_q & sda_s;
  assign byte_d   = {shift_q[6:0], sda_s};
  assign addr_hit = shift_q == {DEV_ADDR, 1'b0};

  // Synchronizers idle high so reset never fakes a START.
  always_ff @(posedge ref_clk or negedge rst) begin
    if (!rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_p_q    <= 1'b1;
      sda_p_q    <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], bus.scl_in};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], bus.sda_in};
      scl_p_q    <= scl_s;
      sda_p_q    <= sda_s;
    end
  end

  always_ff @(posedge ref_clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      ptr_q      <= '0;
      sda_oe_q   <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_reg_q   <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      wr_valid_q <= 1'b0;
      if (stop) begin
        state_q  <= IDLE;
        busy_q   <= 1'b0;
        sda_oe_q <= 1'b0;
        cnt_q    <= '0;
      end else if (start) begin
        state_q  <= ADDR;
        busy_q   <= 1'b1;
        sda_oe_q <= 1'b0;
        cnt_q    <= '0;
      end else begin
        unique case (state_q)
          ADDR, REG, DATA: begin
            if (scl_rise && !cnt_q[3]) begin
              shift_q <= byte_d;
              cnt_q   <= cnt_q + 4'd1;
              if (state_q == DATA && cnt_q == 4'd7) begin
                wr_valid_q <= 1'b1;
                wr_reg_q   <= ptr_q;
                wr_data_q  <= byte_d;
                ptr_q      <= ptr_q + 8'd1;
              end
            end else if (scl_fall && cnt_q[3]) begin
              unique case (state_q)
                ADDR: begin
                  if (addr_hit) begin
                    state_q  <= ACK_A;
                    sda_oe_q <= 1'b1;
                  end else begin
                    state_q  <= IGNORE;
                  end
                end
                REG: begin
                  ptr_q    <= shift_q;
                  state_q  <= ACK_R;
                  sda_oe_q <= 1'b1;
                end
                default: begin
                  state_q  <= ACK_D;
                  sda_oe_q <= 1'b1;
                end
              endcase
            end
          end
          ACK_A, ACK_R, ACK_D: begin
            if (scl_fall) begin
              sda_oe_q <= 1'b0;
              cnt_q    <= '0;
              state_q  <= (state_q == ACK_A) ? REG : DATA;
            end
          end
          IGNORE:  sda_oe_q <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  assign bus.sda_oe   = sda_oe_q;
  assign bus.wr_valid = wr_valid_q;
  assign bus.wr_reg   = wr_reg_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.busy     = busy_q;
endmodule

// File: tb/tb_i2c_target_rx.sv
// Bench for i2c_target_rx: bit-banged I2C master,
// open-drain SDA, transaction-level reference model.
module tb_i2c_target_rx;
  localparam logic [6:0] DEV = 7'h21;
  localparam int         SS  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic scl_drv = 1'b1;
  logic sda_drv = 1'b1;
  always #5 clk = ~clk;

  i2c_target_rx_if bus();
  assign bus.scl_in = scl_drv;
  assign bus.sda_in = sda_drv & ~bus.sda_oe;

  i2c_target_rx #(
    .DEV_ADDR(DEV),
    .SYNC_STAGES(SS)
  ) dut (
    .ref_clk(clk),
    .rst(rst_n),
    .bus(bus)
  );

  int n_chk = 0;
  int n_fail = 0;
  int q = 8;
  int viol = 0;
  bit in_ack = 1'b0;
  bit wv_prev = 1'b0;
  logic [15:0] got_q[$];
  logic [7:0]  tx[$];

  task automatic chk(string tag,
                     logic [31:0] got,
                     logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.wr_valid)
        got_q.push_back({bus.wr_reg, bus.wr_data});
      if (bus.wr_valid && wv_prev) viol++;
      if (bus.sda_oe &&
          (!bus.busy || (scl_drv && !in_ack)))
        viol++;
      wv_prev = bus.wr_valid;
    end else begin
      wv_prev = 1'b0;
    end
  end

  task automatic wait_q();
    repeat (q) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_drv = 1'b1; wait_q();
    scl_drv = 1'b1; wait_q();
    sda_drv = 1'b0; wait_q();
    scl_drv = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    sda_drv = 1'b0; wait_q();
    scl_drv = 1'b1; wait_q();
    sda_drv = 1'b1; wait_q();
  endtask

  task automatic i2c_bit(input logic b);
    sda_drv = b;    wait_q();
    scl_drv = 1'b1; wait_q(); wait_q();
    scl_drv = 1'b0; wait_q();
  endtask

  task automatic ack_bit(output bit ack,
                         output int rel);
    in_ack  = 1'b1;
    sda_drv = 1'b1; wait_q();
    scl_drv = 1'b1; wait_q();
    ack = bus.sda_oe; wait_q();
    scl_drv = 1'b0;
    rel = 0;
    while (bus.sda_oe && rel < 12) begin
      @(negedge clk);
      rel++;
    end
    wait_q();
    in_ack = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b,
                           input int nbits,
                           output bit ack,
                           output int rel);
    ack = 1'b0;
    rel = 0;
    for (int i = 0; i < nbits; i++)
      i2c_bit(b[7-i]);
    if (nbits == 8) ack_bit(ack, rel);
  endtask

  task automatic put_byte(input string tag,
                          input logic [7:0] b,
                          input bit exp_ack);
    bit ack;
    int rel;
    send_byte(b, 8, ack, rel);
    chk(tag, ack, exp_ack);
    if (ack) chk({tag, "_rel"}, rel <= SS + 2, 1);
  endtask

  task automatic cmp_strobes(string tag,
                             logic [15:0] exp_q[$]);
    chk({tag, "_nstrb"}, got_q.size(), exp_q.size());
    foreach (exp_q[i])
      if (i < got_q.size())
        chk($sformatf("%s_strb%0d", tag, i),
            got_q[i], exp_q[i]);
  endtask

  // Model: ACK every full byte iff the first is a
  // write to DEV; data byte k lands at reg+k mod 256.
  task automatic run_txn(input string tag,
                         input int cut,
                         input int qq);
    logic [15:0] exp_q[$];
    logic [7:0]  r;
    bit ok;
    int nfull;
    q = qq;
    got_q.delete();
    ok = (tx[0] == {DEV, 1'b0});
    nfull = (cut != 0) ? tx.size() - 1 : tx.size();
    for (int i = 2; i < nfull; i++) begin
      r = tx[1] + 8'(i - 2);
      if (ok) exp_q.push_back({r, tx[i]});
    end
    i2c_start();
    chk({tag, "_busy"}, bus.busy, 1);
    for (int i = 0; i < nfull; i++)
      put_byte($sformatf("%s_ack%0d", tag, i),
               tx[i], ok);
    if (cut != 0) begin
      bit a;
      int rl;
      send_byte(tx[tx.size()-1], cut, a, rl);
    end
    i2c_stop();
    repeat (6) @(negedge clk);
    chk({tag, "_idle"}, bus.busy, 0);
    chk({tag, "_oe"}, bus.sda_oe, 0);
    cmp_strobes(tag, exp_q);
  endtask

  initial begin
    #900us;
    $display("FAIL watchdog: timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] e[$];
    repeat (3) @(negedge clk);
    chk("rst_oe", bus.sda_oe, 0);
    chk("rst_wv", bus.wr_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_reg", bus.wr_reg, 0);
    chk("rst_data", bus.wr_data, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    tx = {8'h42, 8'h12, 8'h80};
    run_txn("t1", 0, 250);

    tx = {8'h44, 8'h12, 8'h34};
    run_txn("t2", 0, 8);

    tx = {8'h43, 8'h12, 8'h34};
    run_txn("t3", 0, 8);

    tx = {8'h42, 8'hFE, 8'hAA, 8'hBB, 8'hCC};
    run_txn("t4", 0, 8);

    q = 8;
    got_q.delete();
    i2c_start();
    put_byte("t5_a", 8'h42, 1);
    put_byte("t5_r", 8'h07, 1);
    i2c_start();
    put_byte("t5_a2", 8'h42, 1);
    put_byte("t5_r2", 8'h05, 1);
    put_byte("t5_d", 8'h11, 1);
    i2c_stop();
    repeat (6) @(negedge clk);
    e = {16'h0511};
    cmp_strobes("t5", e);

    tx = {8'h42, 8'h09, 8'h33};
    run_txn("t5b", 4, 8);

    q = 8;
    got_q.delete();
    i2c_start();
    put_byte("t6_a", 8'h42, 1);
    put_byte("t6_r", 8'h20, 1);
    for (int i = 0; i < 3; i++) i2c_bit(1'b1);
    rst_n = 1'b0;
    #1;
    chk("t6_oe", bus.sda_oe, 0);
    chk("t6_wv", bus.wr_valid, 0);
    chk("t6_busy", bus.busy, 0);
    chk("t6_reg", bus.wr_reg, 0);
    chk("t6_data", bus.wr_data, 0);
    @(negedge clk);
    scl_drv = 1'b1;
    sda_drv = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    tx = {8'h42, 8'h31, 8'h77};
    run_txn("t6b", 0, 8);

    for (int t = 0; t < 16; t++) begin
      int n;
      int cut;
      n = $urandom_range(1, 5);
      tx.delete();
      if ($urandom_range(0, 9) < 7)
        tx.push_back(8'h42);
      else
        tx.push_back(8'($urandom));
      for (int i = 1; i < n; i++)
        tx.push_back(8'($urandom));
      cut = 0;
      if (n > 1 && $urandom_range(0, 3) == 0)
        cut = $urandom_range(1, 7);
      run_txn($sformatf("rnd%0d", t), cut,
              $urandom_range(6, 10));
    end

    chk("invariants", viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
